k2red_sched: RTL and testbench

K2RED_SCHED -- requirements
Module: k2red_sched

---
 rtl/k2red_sched.sv | 175 +++++++++++++++++
 tb/tb_k2red_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k2red_sched.sv
// Two-requester front end for the shared k2red reduction datapath: round-robin issue,
// fixed-latency result tracking and a drain-before-reconfigure handshake.
module k2red_sched #(
  parameter int unsigned W     = 32,
  parameter int unsigned LOG_L = 4,
  parameter int unsigned LAT   = 6,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [W-1:0]       cfg_q,
  input  logic [LOG_L-1:0]   cfg_l1,
  input  logic [LOG_L-1:0]   cfg_l2,
  input  logic [LOG_L-1:0]   cfg_l3,
  output logic               cfg_ready,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2*W-1:0]     req0_a,
  input  logic [TAG_W-1:0]   req0_tag,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2*W-1:0]     req1_a,
  input  logic [TAG_W-1:0]   req1_tag,
  output logic [2*W-1:0]     red_a,
  output logic [W-1:0]       red_q,
  output logic [LOG_L-1:0]   red_l1,
  output logic [LOG_L-1:0]   red_l2,
  output logic [LOG_L-1:0]   red_l3,
  input  logic [W-1:0]       red_c,
  output logic               res_valid,
  output logic               res_src,
  output logic [TAG_W-1:0]   res_tag,
  output logic [W-1:0]       res_c,
  output logic               busy
);

  localparam int unsigned AW = 2 * W;
  localparam int unsigned CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               ptr;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic               cfg_acc;

  logic               issue_v;
  logic [AW-1:0]      issue_a;
  logic               issue_src;
  logic [TAG_W-1:0]   issue_tag;

  logic [LAT-1:0]     sr_v;
  logic [LAT-1:0]     sr_src;
  logic [TAG_W-1:0]   sr_tag [LAT];
  logic [CW-1:0]      inflight;

  // Config may only land on an empty pipeline so results never mix moduli.
  assign cfg_ready = ~issue_v & ~(|sr_v);
  assign busy      = ~cfg_ready;
  assign cfg_acc   = cfg_we & cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= UNCFG;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      UNCFG:   if (cfg_acc) state_nx = RUN;
      RUN:     if (cfg_we && !cfg_ready) state_nx = DRAIN;
      DRAIN:   if (cfg_acc) state_nx = RUN;
      default: state_nx = UNCFG;
    endcase
  end

  // Round-robin grant; a pending config write blocks all issue.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == RUN && !cfg_we) begin
      if (req0_valid && (!req1_valid || !ptr)) grant0 = 1'b1;
      else if (req1_valid)                     grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_ff @(posedge clk) begin
    if (rst)         ptr <= 1'b0;
    else if (accept) ptr <= grant0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_q  <= '0;
      red_l1 <= '0;
      red_l2 <= '0;
      red_l3 <= '0;
    end else if (cfg_acc) begin
      red_q  <= cfg_q;
      red_l1 <= cfg_l1;
      red_l2 <= cfg_l2;
      red_l3 <= cfg_l3;
    end
  end

  // Idle slots carry zero src/tag so the result tail is clean when invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_v   <= 1'b0;
      issue_a   <= '0;
      issue_src <= 1'b0;
      issue_tag <= '0;
    end else begin
      issue_v   <= accept;
      issue_a   <= grant1 ? req1_a : (grant0 ? req0_a : '0);
      issue_src <= grant1;
      issue_tag <= grant1 ? req1_tag : (grant0 ? req0_tag : '0);
    end
  end

  assign red_a = issue_v ? issue_a : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_v   <= '0;
      sr_src <= '0;
      for (int i = 0; i < int'(LAT); i++) sr_tag[i] <= '0;
    end else begin
      sr_v[0]   <= issue_v;
      sr_src[0] <= issue_src;
      sr_tag[0] <= issue_tag;
      for (int i = 1; i < int'(LAT); i++) begin
        sr_v[i]   <= sr_v[i-1];
        sr_src[i] <= sr_src[i-1];
        sr_tag[i] <= sr_tag[i-1];
      end
    end
  end

  assign res_valid = sr_v[LAT-1];
  assign res_src   = sr_src[LAT-1];
  assign res_tag   = sr_tag[LAT-1];
  assign res_c     = res_valid ? red_c : '0;

  // Saturating occupancy count; the assertions flag any tracking slip.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (accept && !res_valid) begin
      if (inflight != CW'(LAT + 1)) inflight <= inflight + CW'(1);
    end else if (!accept && res_valid) begin
      if (inflight != '0) inflight <= inflight - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(accept && !res_valid && inflight == CW'(LAT + 1)));
      assert (!(!accept && res_valid && inflight == '0));
    end
  end

endmodule

// File: tb/tb_k2red_sched.sv
// Bench for k2red_sched: stand-in reduction pipeline, ready-vector table,
// result scoreboard and directed config/drain/reset sequences.
module tb_k2red_sched;

  localparam int unsigned W     = 32;
  localparam int unsigned LOG_L = 4;
  localparam int unsigned LAT   = 6;
  localparam int unsigned TAG_W = 4;

  localparam logic [63:0] A17 = 64'd2500883870215315764;
  localparam logic [31:0] Q17 = 32'd2148794369;
  localparam logic [31:0] C17 = 32'd1965696994;
  localparam logic [31:0] Q2  = 32'h7fff_e001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [W-1:0]     cfg_q = '0;
  logic [LOG_L-1:0] cfg_l1 = '0, cfg_l2 = '0, cfg_l3 = '0;
  logic             cfg_ready;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [2*W-1:0]   req0_a = '0, req1_a = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic [2*W-1:0]   red_a;
  logic [W-1:0]     red_q;
  logic [LOG_L-1:0] red_l1, red_l2, red_l3;
  logic [W-1:0]     red_c;
  logic             res_valid, res_src;
  logic [TAG_W-1:0] res_tag;
  logic [W-1:0]     res_c;
  logic             busy;

  k2red_sched #(.W(W), .LOG_L(LOG_L), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_l1(cfg_l1), .cfg_l2(cfg_l2), .cfg_l3(cfg_l3),
    .cfg_ready(cfg_ready),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_tag(req1_tag),
    .red_a(red_a), .red_q(red_q), .red_l1(red_l1), .red_l2(red_l2), .red_l3(red_l3),
    .red_c(red_c),
    .res_valid(res_valid), .res_src(res_src), .res_tag(res_tag), .res_c(res_c),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference vector returns its known reduction; anything else gets a cheap mixing map.
  function automatic logic [31:0] dp_fn(input logic [63:0] a, input logic [31:0] q,
                                        input logic [3:0] l1, input logic [3:0] l2,
                                        input logic [3:0] l3);
    if (a == A17 && q == Q17 && l1 == 4'd2 && l2 == 4'd1 && l3 == 4'd3) return C17;
    return a[63:32] ^ a[31:0] ^ q ^ {20'd0, l1, l2, l3};
  endfunction

  logic [31:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_fn(red_a, red_q, red_l1, red_l2, red_l3);
    for (int i = 1; i < int'(LAT); i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign red_c = dp_pipe[LAT-1];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     c;
    int               due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_q = '0;
  logic [3:0]  cur_l1 = '0, cur_l2 = '0, cur_l3 = '0;
  int          last_res_cyc = -100;

  // Scoreboard: push on accept (ready&valid seen mid-cycle), pop on each result.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid) begin
        last_res_cyc = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_res: got res_valid tag %0h expected none (cycle %0d)", res_tag, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_src", 64'(res_src), 64'(e.src));
          check("res_tag", 64'(res_tag), 64'(e.tag));
          check("res_c", 64'(res_c), 64'(e.c));
          check("res_latency", 64'(cyc), 64'(e.due));
        end
      end
      if (req0_valid && req0_ready)
        sb.push_back('{src: 1'b0, tag: req0_tag,
                       c: dp_fn(req0_a, cur_q, cur_l1, cur_l2, cur_l3), due: cyc + int'(LAT) + 1});
      if (req1_valid && req1_ready)
        sb.push_back('{src: 1'b1, tag: req1_tag,
                       c: dp_fn(req1_a, cur_q, cur_l1, cur_l2, cur_l3), due: cyc + int'(LAT) + 1});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_we = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_cfg(input logic [31:0] q, input logic [3:0] l1, input logic [3:0] l2,
                        input logic [3:0] l3);
    cfg_we = 1'b1;
    cfg_q = q;
    cfg_l1 = l1;
    cfg_l2 = l2;
    cfg_l3 = l3;
    @(negedge clk);
    check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    step();
    cfg_we = 1'b0;
    cur_q = q;
    cur_l1 = l1;
    cur_l2 = l2;
    cur_l3 = l3;
    @(negedge clk);
    check("red_q", 64'(red_q), 64'(q));
    check("red_l", 64'({red_l1, red_l2, red_l3}), 64'({l1, l2, l3}));
    step();
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    step();
  endtask

  typedef struct {
    logic             v0, v1, we;
    logic [TAG_W-1:0] t0, t1;
    logic             r0, r1;
  } rvec_t;

  rvec_t rt [8];
  bit    got;

  initial begin
    // Ready vectors from a fresh pointer of 0; the last row raises a config write.
    rt[0] = '{1'b1, 1'b1, 1'b0, 4'h1, 4'h2, 1'b1, 1'b0};
    rt[1] = '{1'b1, 1'b1, 1'b0, 4'h3, 4'h4, 1'b0, 1'b1};
    rt[2] = '{1'b0, 1'b1, 1'b0, 4'h5, 4'h6, 1'b0, 1'b1};
    rt[3] = '{1'b1, 1'b1, 1'b0, 4'h7, 4'h8, 1'b1, 1'b0};
    rt[4] = '{1'b1, 1'b0, 1'b0, 4'h9, 4'ha, 1'b1, 1'b0};
    rt[5] = '{1'b0, 1'b0, 1'b0, 4'hb, 4'hc, 1'b0, 1'b0};
    rt[6] = '{1'b1, 1'b1, 1'b0, 4'hd, 4'he, 1'b0, 1'b1};
    rt[7] = '{1'b1, 1'b1, 1'b1, 4'hf, 4'h0, 1'b0, 1'b0};

    do_reset();
    @(negedge clk);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_fields", 64'({res_src, res_tag}), 64'd0);
    check("rst_res_c", 64'(res_c), 64'd0);
    check("rst_red_q", 64'(red_q), 64'd0);
    check("rst_red_l", 64'({red_l1, red_l2, red_l3}), 64'd0);
    check("rst_red_a", red_a, 64'd0);
    step();

    // Requests before any configuration are never granted.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = {$urandom, $urandom};
    req1_a = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("uncfg_ready", 64'({req0_ready, req1_ready}), 64'd0);
      step();
    end
    idle();
    repeat (10) step();

    // Reference reduction through requester 0.
    do_cfg(Q17, 4'd2, 4'd1, 4'd3);
    req0_valid = 1'b1;
    req0_a = A17;
    req0_tag = 4'd5;
    @(negedge clk);
    check("ref_ready", 64'(req0_ready), 64'd1);
    step();
    idle();
    @(negedge clk);
    check("ref_red_a", red_a, A17);
    check("ref_busy", 64'(busy), 64'd1);
    check("ref_cfg_ready", 64'(cfg_ready), 64'd0);
    wait_empty();
    @(negedge clk);
    check("idle_red_a", red_a, 64'd0);
    check("idle_res_c", 64'(res_c), 64'd0);
    step();

    // Both requesters held valid from a fresh pointer: strict alternation.
    do_reset();
    do_cfg(Q17, 4'd2, 4'd1, 4'd3);
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_a = {$urandom, $urandom};
      req1_a = {$urandom, $urandom};
      req0_tag = TAG_W'(i);
      req1_tag = TAG_W'(i + 8);
      @(negedge clk);
      check($sformatf("alt%0d_ready", i), 64'({req0_ready, req1_ready}),
            (i % 2 == 0) ? 64'd2 : 64'd1);
      step();
    end
    idle();
    step();

    // Ready table; the final row requests a config with work still in flight.
    for (int i = 0; i < 8; i++) begin
      req0_valid = rt[i].v0;
      req1_valid = rt[i].v1;
      cfg_we = rt[i].we;
      cfg_q = Q2;
      cfg_l1 = 4'd3;
      cfg_l2 = 4'd2;
      cfg_l3 = 4'd1;
      req0_a = {$urandom, $urandom};
      req1_a = {$urandom, $urandom};
      req0_tag = rt[i].t0;
      req1_tag = rt[i].t1;
      @(negedge clk);
      check($sformatf("rt%0d_r0", i), 64'(req0_ready), 64'(rt[i].r0));
      check($sformatf("rt%0d_r1", i), 64'(req1_ready), 64'(rt[i].r1));
      if (i < 7) step();
    end
    check("drain_cfg_ready", 64'(cfg_ready), 64'd0);

    // Hold the config write until the pipeline has emptied.
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      step();
      @(negedge clk);
      check("drain_ready", 64'({req0_ready, req1_ready}), 64'd0);
      if (cfg_ready) begin
        got = 1'b1;
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("cfg_after_last_res", 64'(cyc - last_res_cyc), 64'd1);
      end
    end
    if (!got) check("drain_cfg_timeout", 64'(cfg_ready), 64'd1);
    step();
    idle();
    cur_q = Q2;
    cur_l1 = 4'd3;
    cur_l2 = 4'd2;
    cur_l3 = 4'd1;
    @(negedge clk);
    check("new_red_q", 64'(red_q), 64'(Q2));
    check("new_red_l", 64'({red_l1, red_l2, red_l3}), 64'h321);
    step();

    // Reset two cycles after an accept discards the operation.
    req1_valid = 1'b1;
    req1_a = {$urandom, $urandom};
    req1_tag = 4'd9;
    @(negedge clk);
    check("pre_rst_ready", 64'(req1_ready), 64'd1);
    step();
    idle();
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
      check("post_rst_idle", 64'({cfg_ready, busy}), 64'd2);
      step();
    end
    idle();
    check("post_rst_red_q", 64'(red_q), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish by 200000");
    $fatal(1);
  end

endmodule
